// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: branch type encodings, flush default and taken-condition helper
package branch_resolve_pkg;
  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_J    = 3'd3,
    BR_JAL  = 3'd4,
    BR_JR   = 3'd5,
    BR_BEX  = 3'd6,
    BR_RSVD = 3'd7
  } br_type_e;
  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;
  localparam int FLUSH_CYCLES_DEF = 2;
  // reserved code falls through every term, so it behaves as NONE
  function automatic logic br_taken(logic [2:0] t, logic ne, logic lt, logic rs);
    return (t == BR_BNE && ne) || (t == BR_BLT && lt) || (t == BR_BEX && rs) ||
           t == BR_J || t == BR_JAL || t == BR_JR;
  endfunction
endpackage

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: X-stage resolution inputs and fetch/flush outputs
interface branch_resolve_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             stall;
  logic [2:0]       br_type;
  logic             is_not_equal;
  logic             is_less_than;
  logic             rstatus_nonzero;
  logic [31:0]      pc_plus1;
  logic [16:0]      imm;
  logic [26:0]      jtarget;
  logic [31:0]      jr_value;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             flush_fd;
  logic             flush_dx;
  logic             busy;
  logic [CNT_W-1:0] taken_count;
  modport master(
    output in_valid, stall, br_type, is_not_equal, is_less_than, rstatus_nonzero,
           pc_plus1, imm, jtarget, jr_value,
    input  redirect, redirect_pc, flush_fd, flush_dx, busy, taken_count
  );
  modport slave(
    input  in_valid, stall, br_type, is_not_equal, is_less_than, rstatus_nonzero,
           pc_plus1, imm, jtarget, jr_value,
    output redirect, redirect_pc, flush_fd, flush_dx, busy, taken_count
  );
endinterface

// File: rtl/branch_target_adder.sv
// branch_target_adder: pc_plus1 plus sign-extended 17-bit immediate, wrapping mod 2^32
module branch_target_adder (
  input  logic [31:0] pc_i,
  input  logic [16:0] imm_i,
  output logic [31:0] sum_o
);
  assign sum_o = pc_i + {{15{imm_i[16]}}, imm_i};
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: resolves X-stage branches into a registered redirect plus a timed flush window
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input logic clock,
  input logic reset,
  branch_resolve_if.slave bus
);
  localparam logic [2:0] CNT_LAST = 3'(FLUSH_CYCLES - 1);
  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             redirect_q;
  logic [31:0]      redirect_pc_q;
  logic [CNT_W-1:0] taken_q;
  logic             accept, take;
  logic [31:0]      br_sum, target;
  branch_target_adder u_adder (
    .pc_i  (bus.pc_plus1),
    .imm_i (bus.imm),
    .sum_o (br_sum)
  );
  assign accept = state_q == ST_IDLE && bus.in_valid && !bus.stall;
  assign take   = accept && br_taken(bus.br_type, bus.is_not_equal, bus.is_less_than,
                                     bus.rstatus_nonzero);
  assign target = (bus.br_type == BR_BNE || bus.br_type == BR_BLT) ? br_sum :
                  bus.br_type == BR_JR ? bus.jr_value : {5'b0, bus.jtarget};
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      taken_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_q    <= take;
      redirect_pc_q <= take ? target : redirect_pc_q;
      taken_q       <= (take && !(&taken_q)) ? taken_q + 1'b1 : taken_q;
    end
  end
  // the window ends after the cycle whose countdown reads zero
  always_comb begin
    state_d = state_q == ST_IDLE ? (take ? ST_FLUSH : ST_IDLE) :
              (cnt_q == 3'd0 ? ST_IDLE : ST_FLUSH);
    cnt_d   = take ? CNT_LAST : (state_q == ST_FLUSH && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
  end
  always_comb begin
    bus.busy        = state_q == ST_FLUSH;
    bus.flush_fd    = state_q == ST_FLUSH;
    bus.flush_dx    = state_q == ST_FLUSH;
    bus.redirect    = redirect_q;
    bus.redirect_pc = redirect_pc_q;
    bus.taken_count = taken_q;
  end
endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: number of cycles flush_fd/flush_dx stay asserted after a redirect (legal 1..7).
REQ-002 Parameter CNT_W, default 16: width of the taken-branch performance counter.
REQ-003 clock  input  1  single block clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  X-stage instruction present and qualified for resolution.
REQ-006 stall  input  1  pipeline stall; holds X stage, blocks acceptance.
REQ-007 br_type  input  3  NONE=0, BNE=1, BLT=2, J=3, JAL=4, JR=5, BEX=6; 7 is reserved and treated as NONE.
REQ-008 is_not_equal  input  1  ALU flag: operand difference nonzero.
REQ-009 is_less_than  input  1  ALU flag: signed less-than result.
REQ-010 rstatus_nonzero  input  1  status register nonzero (BEX condition).
REQ-011 pc_plus1  input  32  PC+1 of X-stage instruction.
REQ-012 imm  input  17  branch immediate, two's complement.
REQ-013 jtarget  input  27  J/JAL/BEX target field.
REQ-014 jr_value  input  32  register value for JR.
REQ-015 redirect  output  1  one-cycle pulse: fetch reloads PC.
REQ-016 redirect_pc  output  32  new PC; valid while redirect=1.
REQ-017 flush_fd  output  1  squash F/D latch.
REQ-018 flush_dx  output  1  squash D/X latch.
REQ-019 busy  output  1  flush window active; new instructions ignored.
REQ-020 taken_count  output  CNT_W  count of redirects since reset.

Function
REQ-021 Acceptance occurs in a cycle where state=IDLE, in_valid=1, stall=0; there is no other acceptance.
REQ-022 Taken conditions: BNE when is_not_equal=1; BLT when is_less_than=1; J, JAL, JR always; BEX when rstatus_nonzero=1; NONE and reserved never.
REQ-023 Targets: BNE/BLT = pc_plus1 + sign-extended imm, modulo 2^32 (wraps, no overflow flag); J/JAL/BEX = {5'b0, jtarget}; JR = jr_value.
REQ-024 An accepted taken branch causes redirect=1 with redirect_pc in the next cycle (latency 1, registered), for exactly one cycle.
REQ-025 flush_fd and flush_dx assert in the same cycle as redirect and remain high for exactly FLUSH_CYCLES consecutive cycles.
REQ-026 FSM: IDLE -> FLUSH on a taken acceptance; FLUSH counts down FLUSH_CYCLES and returns to IDLE after the last flush cycle; busy=1 exactly while in FLUSH.
REQ-027 In FLUSH, in_valid and br_type are ignored; the flush countdown continues regardless of stall.
REQ-028 A not-taken acceptance produces no redirect or flush and does not change state; redirect_pc holds its last value.
REQ-029 Back-to-back taken instructions: the first is accepted and the second is squashed (ignored while busy); the earliest acceptance after a redirect is the cycle busy falls to 0.
REQ-030 taken_count increments by 1 per redirect and saturates at 2^CNT_W-1.

Reset
REQ-031 reset=1 forces state=IDLE, redirect=0, redirect_pc=0, flush_fd=0, flush_dx=0, busy=0, taken_count=0 at the next rising edge.
REQ-032 reset asserted mid-FLUSH aborts the window: flush outputs are 0 in the cycle after reset is sampled, and no pending redirect survives.
REQ-033 reset takes priority over acceptance in the same cycle.

Structure
REQ-034 The br_type encodings, the FLUSH_CYCLES default and the reserved-code rule belong in a shared package.
REQ-035 The target addition is one sub-module, branch_target_adder (32-bit, combinational, sign-extends imm internally).

Verification
REQ-036 BNE, pc_plus1=0x00000010, imm=0x1FFFC (-4), is_not_equal=1 -> next cycle redirect=1, redirect_pc=0x0000000C; flush high for 2 cycles; taken_count=1.
REQ-037 BNE with is_not_equal=0 -> no redirect, no flush, busy=0, taken_count unchanged.
REQ-038 BLT, pc_plus1=0xFFFFFFFF, imm=0x00002, is_less_than=1 -> redirect_pc=0x00000001 (wrap).
REQ-039 JR jr_value=0x1234 accepted, BEX valid in the next two cycles -> one redirect only, to 0x1234; BEX is accepted only once busy=0.
REQ-040 J accepted, reset asserted during the first flush cycle -> all outputs 0 the following cycle, state IDLE, taken_count=0.
REQ-041 Taken J with stall=1 -> no acceptance; release stall -> redirect to {5'b0,jtarget} one cycle later.
